// File: rtl/spi_seq_pkg.sv
// Shared types and width helpers for the SPI table sequencer.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StWaitDone,
    StGap,
    StFinish
  } state_e;

  // Word width of the shared SPI master.
  localparam int unsigned SpiWordW = 20;

  // Table index width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Sequence length width: one extra bit so that len == depth is representable.
  function automatic int unsigned len_width(input int unsigned depth);
    return idx_width(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_seq_table.sv
// DEPTH x WORD_W word table: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module spi_seq_table
  import spi_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WORD_W = SpiWordW
) (
  input  logic                        clk_in,
  input  logic                        we_in,
  input  logic [idx_width(DEPTH)-1:0] waddr_in,
  input  logic [WORD_W-1:0]           wdata_in,
  input  logic [idx_width(DEPTH)-1:0] raddr_in,
  output logic [WORD_W-1:0]           rdata_out
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Write port: new word visible on the read port from the next cycle.
  always_ff @(posedge clk_in) begin
    if (we_in) begin
      mem_q[waddr_in] <= wdata_in;
    end
  end

  assign rdata_out = mem_q[raddr_in];

endmodule

// File: rtl/spi_seq_ctrl.sv
// Sequencer that walks the word table through the shared SPI master one transaction at a
// time, captures each returned word and pulses done at the end of the sequence.
// Optional watchdog on the SPI handshake: define SPI_SEQ_TIMEOUT_EN.
module spi_seq_ctrl
  import spi_seq_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned WORD_W         = SpiWordW,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        cfg_we_in,
  input  logic [idx_width(DEPTH)-1:0] cfg_addr_in,
  input  logic [WORD_W-1:0]           cfg_data_in,
  input  logic [len_width(DEPTH)-1:0] seq_len_in,
  input  logic                        start_in,
  output logic                        busy_out,
  output logic                        done_out,
  output logic                        err_out,
  output logic [WORD_W-1:0]           rx_data_out,
  output logic [idx_width(DEPTH)-1:0] rx_idx_out,
  output logic                        rx_valid_out,
  output logic [WORD_W-1:0]           spi_data_out,
  output logic                        spi_trigger_out,
  input  logic                        spi_busy_in,
  input  logic                        spi_valid_in,
  input  logic [WORD_W-1:0]           spi_rdata_in
);

  localparam int unsigned IdxW    = idx_width(DEPTH);
  localparam int unsigned LenW    = len_width(DEPTH);
  localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // GAP_CYCLES = 0 still spends one pass-through cycle in GAP.
  localparam int unsigned GapLast = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic [IdxW-1:0]   rx_idx_q, rx_idx_d;
  logic              rx_valid_q, rx_valid_d;
  logic [WORD_W-1:0] spi_data_q, spi_data_d;
  logic [WORD_W-1:0] tbl_rdata;
  logic              to_hit;

  spi_seq_table #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_table (
    .clk_in    (clk_in),
    .we_in     (cfg_we_in && (state_q == StIdle)),
    .waddr_in  (cfg_addr_in),
    .wdata_in  (cfg_data_in),
    .raddr_in  (idx_d),
    .rdata_out (tbl_rdata)
  );

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [ToW-1:0] to_q, to_d;

  // Watchdog restarts on every state change, so WAIT_ACK and WAIT_DONE each get a full budget.
  always_comb begin
    to_d = (state_d != state_q) ? '0 : to_q + ToW'(1);
  end

  // Watchdog counter register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end

  assign to_hit = (state_q inside {StWaitAck, StWaitDone}) &&
                  (to_q == ToW'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  // Next-state, counters, capture and trigger.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    len_d           = len_q;
    gap_d           = gap_q;
    done_d          = 1'b0;
    err_d           = err_q;
    rx_data_d       = rx_data_q;
    rx_idx_d        = rx_idx_q;
    rx_valid_d      = 1'b0;
    spi_trigger_out = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          len_d   = (seq_len_in > LenW'(DEPTH)) ? LenW'(DEPTH) : seq_len_in;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = (len_d == '0) ? StFinish : StIssue;
        end
      end
      StIssue: begin
        if (!spi_busy_in) begin
          spi_trigger_out = 1'b1;
          state_d         = StWaitAck;
        end
      end
      StWaitAck: begin
        if (spi_busy_in) begin
          state_d = StWaitDone;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end
      end
      StWaitDone: begin
        // A valid coincident with the busy fall is still captured.
        if (spi_valid_in) begin
          rx_data_d  = spi_rdata_in;
          rx_idx_d   = idx_q;
          rx_valid_d = 1'b1;
        end
        if (!spi_busy_in) begin
          gap_d   = '0;
          state_d = StGap;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = StFinish;
        end
      end
      StGap: begin
        if (gap_q == GapW'(GapLast)) begin
          // Compare against len-1 so len == DEPTH never needs idx to wrap.
          if ({1'b0, idx_q} == len_q - LenW'(1)) begin
            state_d = StFinish;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StIssue;
          end
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outgoing word is loaded on each entry to ISSUE and held until the next one.
    spi_data_d = ((state_d == StIssue) && (state_q != StIssue)) ? tbl_rdata : spi_data_q;
  end

  // State and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      len_q      <= '0;
      gap_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_idx_q   <= '0;
      rx_valid_q <= 1'b0;
      spi_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rx_data_q  <= rx_data_d;
      rx_idx_q   <= rx_idx_d;
      rx_valid_q <= rx_valid_d;
      spi_data_q <= spi_data_d;
    end
  end

  assign busy_out     = state_q inside {StIssue, StWaitAck, StWaitDone, StGap};
  assign done_out     = done_q;
  assign err_out      = err_q;
  assign rx_data_out  = rx_data_q;
  assign rx_idx_out   = rx_idx_q;
  assign rx_valid_out = rx_valid_q;
  assign spi_data_out = spi_data_q;

endmodule

// File: tb/tb_spi_seq_ctrl.sv
// Directed bench for spi_seq_ctrl with a behavioural SPI master that stays busy for 40 cycles
// and returns the bitwise inverse of the sent word, valid coincident with its busy fall.
module tb_spi_seq_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WW    = 20;
  localparam int unsigned IW    = 4;
  localparam int unsigned LW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_addr = '0;
  logic [WW-1:0] cfg_data = '0;
  logic [LW-1:0] seq_len = '0;
  logic          start = 1'b0;
  logic          busy, done, err, rx_valid, spi_trig;
  logic [WW-1:0] rx_data, spi_data;
  logic [IW-1:0] rx_idx;

  logic          m_busy  = 1'b0;
  logic          m_valid = 1'b0;
  logic [WW-1:0] m_rdata = '0;
  logic [WW-1:0] m_word  = '0;
  int            m_cnt   = 0;
  logic          m_mute  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_seq_ctrl #(
    .DEPTH          (DEPTH),
    .WORD_W         (WW),
    .GAP_CYCLES     (8),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .cfg_we_in       (cfg_we),
    .cfg_addr_in     (cfg_addr),
    .cfg_data_in     (cfg_data),
    .seq_len_in      (seq_len),
    .start_in        (start),
    .busy_out        (busy),
    .done_out        (done),
    .err_out         (err),
    .rx_data_out     (rx_data),
    .rx_idx_out      (rx_idx),
    .rx_valid_out    (rx_valid),
    .spi_data_out    (spi_data),
    .spi_trigger_out (spi_trig),
    .spi_busy_in     (m_busy),
    .spi_valid_in    (m_valid),
    .spi_rdata_in    (m_rdata)
  );

  // SPI master model.
  always @(posedge clk) begin
    m_valid <= 1'b0;
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_rdata <= ~m_word;
      end
    end else if (spi_trig && !m_mute) begin
      m_word <= spi_data;
      m_busy <= 1'b1;
      m_cnt  <= 40;
    end
  end

  // Monitor: cycle count, triggers, captured words, done pulses.
  int            cyc = 0;
  logic [WW-1:0] trig_q [$];
  int            trig_cyc_q [$];
  logic [WW-1:0] rx_q [$];
  logic [IW-1:0] rxi_q [$];
  int            done_cnt = 0;
  int            bad_trig = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (spi_trig) begin
      trig_q.push_back(spi_data);
      trig_cyc_q.push_back(cyc);
      if (m_busy) bad_trig <= bad_trig + 1;
    end
    if (rx_valid) begin
      rx_q.push_back(rx_data);
      rxi_q.push_back(rx_idx);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_entry(input int a, input logic [WW-1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a[IW-1:0];
    cfg_data = d;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    seq_len = len[LW-1:0];
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_done_timeout: done_out not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0)     begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_tests++; if (err !== 1'b0)      begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rxv: got %b want 0", rx_valid); end
    n_tests++; if (spi_trig !== 1'b0) begin n_fail++; $display("FAIL rst_trig: got %b want 0", spi_trig); end
    n_tests++; if (rx_data !== '0)    begin n_fail++; $display("FAIL rst_rxd: got %h want 0", rx_data); end
    n_tests++; if (rx_idx !== '0)     begin n_fail++; $display("FAIL rst_rxi: got %h want 0", rx_idx); end
    n_tests++; if (spi_data !== '0)   begin n_fail++; $display("FAIL rst_spid: got %h want 0", spi_data); end
  endtask

  task automatic test_basic();
    logic [WW-1:0] tx [3];
    logic [WW-1:0] rx [3];
    int t0, r0, d0, sp;
    tx[0] = 20'h12345; tx[1] = 20'hABCDE; tx[2] = 20'h00F0F;
    rx[0] = 20'hEDCBA; rx[1] = 20'h54321; rx[2] = 20'hFF0F0;
    for (int i = 0; i < 3; i++) write_entry(i, tx[i]);
    t0 = trig_q.size(); r0 = rx_q.size(); d0 = done_cnt;
    pulse_start(3);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_done(400, "basic");
    tick(3);
    n_tests++;
    if (trig_q.size() - t0 != 3) begin
      n_fail++; $display("FAIL basic_ntrig: got %0d want 3", trig_q.size() - t0);
    end
    n_tests++;
    if (rx_q.size() - r0 != 3) begin
      n_fail++; $display("FAIL basic_nrx: got %0d want 3", rx_q.size() - r0);
    end
    if (trig_q.size() - t0 >= 3 && rx_q.size() - r0 >= 3) begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (trig_q[t0+i] !== tx[i]) begin
          n_fail++; $display("FAIL basic_tx%0d: got %h want %h", i, trig_q[t0+i], tx[i]);
        end
        n_tests++;
        if (rx_q[r0+i] !== rx[i]) begin
          n_fail++; $display("FAIL basic_rx%0d: got %h want %h", i, rx_q[r0+i], rx[i]);
        end
        n_tests++;
        if (rxi_q[r0+i] !== IW'(i)) begin
          n_fail++; $display("FAIL basic_rxidx%0d: got %0d want %0d", i, rxi_q[r0+i], i);
        end
      end
      for (int i = 1; i < 3; i++) begin
        sp = trig_cyc_q[t0+i] - trig_cyc_q[t0+i-1];
        n_tests++;
        if (sp < 50 || sp > 52) begin
          n_fail++; $display("FAIL basic_spacing%0d: got %0d want 50..52", i, sp);
        end
      end
    end
    n_tests++;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL basic_ndone: got %0d want 1", done_cnt - d0);
    end
    n_tests++; if (bad_trig != 0) begin n_fail++; $display("FAIL trig_while_busy: got %0d want 0", bad_trig); end
    n_tests++; if (err !== 1'b0)  begin n_fail++; $display("FAIL basic_err: got %b want 0", err); end
  endtask

  task automatic test_len_zero();
    int t0 = trig_q.size();
    pulse_start(0);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL len0_early: got %b want 0", done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy: got %b want 0", busy); end
    tick(1);
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL len0_done: got %b want 1", done); end
    tick(3);
    n_tests++;
    if (trig_q.size() != t0) begin
      n_fail++; $display("FAIL len0_trig: got %0d want 0", trig_q.size() - t0);
    end
  endtask

  task automatic test_len_over();
    logic [WW-1:0] v [DEPTH];
    int t0, r0;
    for (int i = 0; i < DEPTH; i++) begin
      v[i] = 20'h30000 + WW'(i) * 20'h00111;
      write_entry(i, v[i]);
    end
    t0 = trig_q.size(); r0 = rx_q.size();
    pulse_start(20);
    wait_done(1500, "len20");
    tick(3);
    n_tests++;
    if (trig_q.size() - t0 != DEPTH) begin
      n_fail++; $display("FAIL len20_ntrig: got %0d want %0d", trig_q.size() - t0, DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        n_tests++;
        if (trig_q[t0+i] !== v[i]) begin
          n_fail++; $display("FAIL len20_tx%0d: got %h want %h", i, trig_q[t0+i], v[i]);
        end
      end
    end
    n_tests++;
    if (rx_q.size() - r0 != DEPTH) begin
      n_fail++; $display("FAIL len20_nrx: got %0d want %0d", rx_q.size() - r0, DEPTH);
    end else begin
      n_tests++;
      if (rxi_q[r0+DEPTH-1] !== 4'hF) begin
        n_fail++; $display("FAIL len20_lastidx: got %0d want 15", rxi_q[r0+DEPTH-1]);
      end
    end
  endtask

  task automatic test_ignore_while_busy();
    int t0, d0;
    bit got;
    write_entry(0, 20'h11111);
    write_entry(1, 20'h22222);
    t0 = trig_q.size(); d0 = done_cnt;
    pulse_start(2);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (trig_q.size() > t0);
    end
    tick(5);
    seq_len  = 5'd1;
    start    = 1'b1;
    cfg_we   = 1'b1;
    cfg_addr = 4'd1;
    cfg_data = 20'h55555;
    @(negedge clk);
    start    = 1'b0;
    cfg_we   = 1'b0;
    wait_done(400, "ignore");
    tick(3);
    n_tests++;
    if (trig_q.size() - t0 != 2) begin
      n_fail++; $display("FAIL ign_ntrig: got %0d want 2", trig_q.size() - t0);
    end else begin
      n_tests++;
      if (trig_q[t0+1] !== 20'h22222) begin
        n_fail++; $display("FAIL ign_word1: got %h want 22222", trig_q[t0+1]);
      end
    end
    n_tests++;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL ign_ndone: got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int t0, r0, t1;
    bit got;
    write_entry(0, 20'h12345);
    write_entry(1, 20'hABCDE);
    write_entry(2, 20'h00F0F);
    t0 = trig_q.size(); r0 = rx_q.size();
    pulse_start(3);
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = (trig_q.size() >= t0 + 2);
    end
    tick(5);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_pre: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_tests++; if (spi_trig !== 1'b0) begin n_fail++; $display("FAIL rmid_trig: got %b want 0", spi_trig); end
    for (int i = 0; i < 100 && m_busy; i++) @(negedge clk);
    tick(3);
    n_tests++;
    if (rx_q.size() - r0 != 1) begin
      n_fail++; $display("FAIL rmid_nrx: got %0d want 1", rx_q.size() - r0);
    end
    n_tests++; if (rx_data !== '0) begin n_fail++; $display("FAIL rmid_rxd: got %h want 0", rx_data); end
    t1 = trig_q.size();
    pulse_start(3);
    wait_done(400, "restart");
    tick(3);
    n_tests++;
    if (trig_q.size() - t1 != 3) begin
      n_fail++; $display("FAIL restart_ntrig: got %0d want 3", trig_q.size() - t1);
    end else begin
      n_tests++;
      if (trig_q[t1] !== 20'h12345) begin
        n_fail++; $display("FAIL restart_word0: got %h want 12345", trig_q[t1]);
      end
    end
  endtask

`ifdef SPI_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int t0, d0, dc, dt;
    t0 = trig_q.size(); d0 = done_cnt;
    m_mute = 1'b1;
    pulse_start(3);
    wait_done(300, "timeout");
    dc = cyc;
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", err); end
    tick(5);
    m_mute = 1'b0;
    tick(5);
    n_tests++;
    if (trig_q.size() - t0 != 1) begin
      n_fail++; $display("FAIL to_ntrig: got %0d want 1", trig_q.size() - t0);
    end else begin
      dt = dc - trig_cyc_q[t0];
      n_tests++;
      if (dt < 101 || dt > 103) begin
        n_fail++; $display("FAIL to_latency: got %0d want 101..103", dt);
      end
    end
    n_tests++;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL to_ndone: got %0d want 1", done_cnt - d0);
    end
    pulse_start(1);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b want 0", err); end
    wait_done(200, "to_after");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_len_over();
    test_ignore_while_busy();
    test_reset_mid();
`ifdef SPI_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
